// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
// One transaction in flight at a time; the response is routed back to the granted requester.
module mem_arbiter #(
  parameter int PADDR_W = 20,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_req_en,
  input  logic [PADDR_W-1:0] ic_req_addr,
  output logic               ic_rec_en,
  output logic [PADDR_W-1:0] ic_rec_addr,
  output logic [LINE_W-1:0]  ic_rec_cacheline,
  input  logic               dc_req_en,
  input  logic               dc_req_wen,
  input  logic [PADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0]  dc_req_wdata,
  output logic               dc_rec_en,
  output logic [PADDR_W-1:0] dc_rec_addr,
  output logic [LINE_W-1:0]  dc_rec_cacheline,
  output logic               dc_wack,
  output logic               mem_req_en,
  output logic               mem_req_wen,
  output logic [PADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0]  mem_req_wdata,
  input  logic               mem_rsp_en,
  input  logic [LINE_W-1:0]  mem_rsp_data,
  output logic               busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  logic [1:0]         state;
  logic               last_dc;
  logic               grant_dc;
  logic               cap_wen;
  logic [PADDR_W-1:0] cap_addr;
  logic               pick_dc;

  // DC wins when it is the only requester, or when both request and IC was served last
  always_comb begin
    pick_dc = dc_req_en && (!ic_req_en || !last_dc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      last_dc          <= 1'b1;
      grant_dc         <= 1'b0;
      cap_wen          <= 1'b0;
      cap_addr         <= '0;
      ic_rec_en        <= 1'b0;
      ic_rec_addr      <= '0;
      ic_rec_cacheline <= '0;
      dc_rec_en        <= 1'b0;
      dc_rec_addr      <= '0;
      dc_rec_cacheline <= '0;
      dc_wack          <= 1'b0;
      mem_req_en       <= 1'b0;
      mem_req_wen      <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_wdata    <= '0;
    end else begin
      mem_req_en <= 1'b0;
      ic_rec_en  <= 1'b0;
      dc_rec_en  <= 1'b0;
      dc_wack    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ic_req_en || dc_req_en) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            grant_dc <= pick_dc;
            last_dc  <= pick_dc;
            cap_wen  <= pick_dc && dc_req_wen;
            cap_addr <= pick_dc ? dc_req_addr : ic_req_addr;
            // Strobe registered here so it is high exactly during the ISSUE cycle
            mem_req_en   <= 1'b1;
            mem_req_wen  <= pick_dc && dc_req_wen;
            mem_req_addr <= pick_dc ? dc_req_addr : ic_req_addr;
            if (pick_dc) begin
              mem_req_wdata <= dc_req_wdata;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_en) begin
            state <= S_RESPOND;
            if (!grant_dc) begin
              ic_rec_en        <= 1'b1;
              ic_rec_addr      <= cap_addr;
              ic_rec_cacheline <= mem_rsp_data;
            end else if (cap_wen) begin
              dc_wack <= 1'b1;
            end else begin
              dc_rec_en        <= 1'b1;
              dc_rec_addr      <= cap_addr;
              dc_rec_cacheline <= mem_rsp_data;
            end
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between I-cache refill and D-cache refill/write-back.
- Accepts level-held requests from both caches and grants them round-robin.
- One transaction is outstanding at a time; the memory response is routed back to the requester that was granted.
- Sits between the stage_if / stage_mem cache miss logic and the memory model.

Parameters:
- PADDR_W, 20, physical address width (matches pptr_t)
- LINE_W, 128, cache line width in bits (matches cacheline_t)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ic_req_en  in  1  I-cache refill request, held high until served
- ic_req_addr  in  PADDR_W  I-cache line address
- ic_rec_en  out  1  one-cycle refill-done pulse to I-cache
- ic_rec_addr  out  PADDR_W  address of the delivered line
- ic_rec_cacheline  out  LINE_W  delivered line
- dc_req_en  in  1  D-cache request, held high until served
- dc_req_wen  in  1  1 = write-back, 0 = refill; valid with dc_req_en
- dc_req_addr  in  PADDR_W  D-cache line address
- dc_req_wdata  in  LINE_W  write-back data
- dc_rec_en  out  1  one-cycle refill-done pulse to D-cache
- dc_rec_addr  out  PADDR_W  address of the delivered line
- dc_rec_cacheline  out  LINE_W  delivered line
- dc_wack  out  1  one-cycle write-back-done pulse
- mem_req_en  out  1  one-cycle request strobe to memory
- mem_req_wen  out  1  write strobe qualifier
- mem_req_addr  out  PADDR_W  request address
- mem_req_wdata  out  LINE_W  write data
- mem_rsp_en  in  1  memory completion strobe (read data valid or write ack)
- mem_rsp_data  in  LINE_W  read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory strobe.
  - WAIT: await mem_rsp_en.
  - RESPOND: pulse the requester.
- All outputs are registered.
- Reset (async, any state): state goes to IDLE, and every output goes to 0, including address and data buses. The last_grant register resets to DC, so the I-cache has first priority after reset.
- IDLE:
  - Sampling edge E with ic_req_en=1 or dc_req_en=1 moves the state to ISSUE.
  - If both are high, grant the requester not equal to last_grant. Otherwise grant the single requester.
  - At E, capture grant, addr, wen (0 for IC) and wdata into internal regs, and update last_grant.
- ISSUE (one cycle):
  - mem_req_en=1, with mem_req_wen/addr/wdata taken from the captured regs. The next state is WAIT.
  - mem_req_en is 0 in every other state.
  - mem_req_addr/wdata hold their last value after the strobe.
- WAIT:
  - Stays until mem_rsp_en=1 is sampled at edge M.
  - Then captures mem_rsp_data and moves to RESPOND.
  - There is no timeout.
- RESPOND (one cycle):
  - Granted IC read: ic_rec_en=1 with the captured addr and data.
  - Granted DC read: dc_rec_en=1 with the captured addr and data.
  - DC write: dc_wack=1. No rec_en and no line update.
  - No arbitration happens in RESPOND. The next state is IDLE.
- rec_addr/cacheline outputs hold their last delivered value between pulses.
- Latency:
  - Request sampled at E gives mem_req_en in the cycle after E.
  - mem_rsp_en sampled at M gives the pulse in the cycle after M.
  - The earliest next grant is sampled one cycle after the pulse.
  - Minimum turnaround is 4 cycles per transaction with a zero-wait memory (rsp in the cycle after strobe).
- Requester contract:
  - Hold req_en and the request fields stable until its rec_en/wack pulse.
  - Deassert req_en in the cycle following the pulse.
  - Fields may change only then.
- Requests in ISSUE, WAIT or RESPOND are not captured; they are served later if still held.
- A requester that drops req_en before being granted is never served.
- mem_rsp_en in IDLE, ISSUE or RESPOND is ignored: stray or late responses, including ones after a mid-transaction reset.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
- Reset check: assert rst mid-cycle while in WAIT -> all outputs 0 immediately. Then drive mem_rsp_en=1 with data 0xAA.. -> no rec_en pulse and state stays IDLE.
- Single IC refill: ic_req_en=1, addr=0x01234; memory returns data=0xDEADBEEF_... 3 cycles after the strobe.
  - Required: mem_req_en=1 with addr 0x01234 and wen 0, exactly one cycle.
  - Required: ic_rec_en pulse carrying 0x01234 and the same data, one cycle after rsp.
  - Required: dc_rec_en stays 0.
- Simultaneous requests right after reset: IC 0x00010 and DC read 0x00020 both held.
  - IC is served first, then DC.
  - Then re-raise both -> IC again, i.e. alternation, since last_grant = DC.
- DC write-back: dc_req_wen=1, addr=0x00F00, wdata=0x5555_...
  - Required: mem_req_en and mem_req_wen both 1 with that data.
  - Required: on rsp, dc_wack pulses one cycle, dc_rec_en stays 0, and dc_rec_addr/dc_rec_cacheline keep their previous values.
- Request arrival during WAIT: IC in flight, DC raises req.
  - DC is not issued until IC's RESPOND is done.
  - The DC strobe comes 2 cycles after the ic_rec_en pulse.
- Stray response in IDLE: mem_rsp_en=1 with no request -> no pulses and busy stays 0. Back-to-back IC requests with zero-wait memory -> exactly 4 cycles between consecutive mem_req_en strobes.
